call_latch: RTL

Front-end request stage for the 4-floor elevator. It synchronises and edge-detects the raw hall and car buttons and holds each request until it is served. It also encodes the floor sensors and runs the door-dwell/service sequence that clears served requests. Its latched request vectors drive the elevator controller's button inputs, and the controller's `stop` output feeds back here.

---
 rtl/call_latch.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/call_latch.sv
// ---------------------------------------------------------------------------
// call_latch
//
// Front-end request stage for a 4-floor elevator.
//   * Synchronises and edge-detects the raw hall and car buttons and holds
//     each request as a pending bit until the car serves that floor.
//   * Tracks the last valid floor from the one-hot floor sensors and flags
//     (sticky) any cycle where more than one sensor bit is set.
//   * Runs the door-dwell / service sequence that clears the requests of
//     the floor the car is stopped at.
//
// Ports
//   clk_i          system clock, all state updates on the rising edge
//   reset_i        asynchronous reset, ACTIVE LOW
//   hall_up_i[2:0] raw up-call buttons, floors 1..3 (bit0 = floor 1), async
//   hall_dn_i[2:0] raw down-call buttons, floors 2..4 (bit0 = floor 2), async
//   car_i[3:0]     raw car buttons, floors 1..4 (bit0 = floor 1), async
//   sensor_i[3:0]  floor sensors S1..S4, one-hot when level at a floor
//   stop_i         motor-stopped indication from the controller
//   req_up_o[3:0]  latched up calls (bit3 always 0)
//   req_dn_o[3:0]  latched down calls (bit0 always 0)
//   req_car_o[3:0] latched car calls
//   floor_o[1:0]   last valid floor, 0..3
//   at_floor_o     exactly one sensor bit set this cycle (combinational)
//   door_busy_o    high while dwelling or clearing
//   served_o       one-cycle pulse when the current floor's requests clear
//   sensor_err_o   sticky: more than one sensor bit seen set
//   state_o[1:0]   service FSM state, for debug/observation
//
// Handshakes: none. Requests are level-held bits; the controller reads them
// every cycle and signals service completion only through stop_i/sensor_i.
// ---------------------------------------------------------------------------
module call_latch #(
    parameter int unsigned DWELL = 8   // door-dwell length in cycles, 2..255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] hall_up_i,
    input  logic [2:0] hall_dn_i,
    input  logic [3:0] car_i,
    input  logic [3:0] sensor_i,
    input  logic       stop_i,
    output logic [3:0] req_up_o,
    output logic [3:0] req_dn_o,
    output logic [3:0] req_car_o,
    output logic [1:0] floor_o,
    output logic       at_floor_o,
    output logic       door_busy_o,
    output logic       served_o,
    output logic       sensor_err_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DWELL     = 2'd1,
        S_CLEAR     = 2'd2,
        S_WAIT_MOVE = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

    // -----------------------------------------------------------------------
    // Button synchronisers and rise detection.
    // Bundle layout: [2:0] hall_up, [5:3] hall_dn, [9:6] car.
    // -----------------------------------------------------------------------
    logic [9:0] raw_btn;
    logic [9:0] sync1_q;
    logic [9:0] sync2_q;
    logic [9:0] prev_q;
    logic [9:0] rise;

    assign raw_btn = {car_i, hall_dn_i, hall_up_i};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only a 0->1 transition of the synchronised level counts as a press,
    // so a held button latches once and must be released to press again.
    assign rise = sync2_q & ~prev_q;

    // Re-map presses onto per-floor vectors (index = floor 0..3).
    logic [3:0] rise_up;
    logic [3:0] rise_dn;
    logic [3:0] rise_car;

    assign rise_up  = {1'b0, rise[2:0]};
    assign rise_dn  = {rise[5:3], 1'b0};
    assign rise_car = rise[9:6];

    // -----------------------------------------------------------------------
    // Floor tracker
    // -----------------------------------------------------------------------
    logic       at_floor;
    logic       sensor_multi;
    logic [1:0] sensor_enc;
    logic [1:0] floor_q;
    logic [1:0] floor_d;
    logic       sensor_err_q;
    logic       sensor_err_d;
    logic [3:0] sensor_q;   // previous-cycle sensor, to detect a change in WAIT_MOVE

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign at_floor     = (sensor_i != 4'd0) && ((sensor_i & (sensor_i - 4'd1)) == 4'd0);
    assign sensor_multi = (sensor_i != 4'd0) && !at_floor;

    always_comb begin
        sensor_enc = 2'd0;
        case (sensor_i)
            4'b0001: sensor_enc = 2'd0;
            4'b0010: sensor_enc = 2'd1;
            4'b0100: sensor_enc = 2'd2;
            4'b1000: sensor_enc = 2'd3;
            default: sensor_enc = 2'd0;
        endcase
    end

    always_comb begin
        floor_d      = floor_q;
        sensor_err_d = sensor_err_q;
        if (at_floor) begin
            floor_d = sensor_enc;
        end
        if (sensor_multi) begin
            sensor_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            floor_q      <= 2'd0;
            sensor_err_q <= 1'b0;
            sensor_q     <= 4'd0;
        end else begin
            floor_q      <= floor_d;
            sensor_err_q <= sensor_err_d;
            sensor_q     <= sensor_i;
        end
    end

    // -----------------------------------------------------------------------
    // Service FSM
    // -----------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       parked;   // car stopped and level at a single floor

    assign parked = stop_i && at_floor;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (parked) begin
                    state_d = S_DWELL;
                    cnt_d   = DWELL_LOAD;
                end
            end
            S_DWELL: begin
                // Losing stop or level aborts without clearing anything;
                // the abort takes priority over the dwell expiring.
                if (!parked) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CLEAR: begin
                state_d = S_WAIT_MOVE;
            end
            S_WAIT_MOVE: begin
                if (!(parked && (sensor_i == sensor_q))) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending request bits
    // -----------------------------------------------------------------------
    logic [3:0] floor_dec;
    logic [3:0] press_mask;   // presses ignored: door still open at this floor
    logic [3:0] clr_vec;      // requests being served this cycle
    logic [3:0] req_up_q,  req_up_d;
    logic [3:0] req_dn_q,  req_dn_d;
    logic [3:0] req_car_q, req_car_d;

    assign floor_dec = 4'b0001 << floor_q;

    always_comb begin
        press_mask = 4'd0;
        clr_vec    = 4'd0;
        if (state_q == S_WAIT_MOVE) begin
            press_mask = floor_dec;
        end
        if (state_q == S_CLEAR) begin
            clr_vec = floor_dec;
        end
    end

    // The set term is OR-ed after the clear, so a press landing on the same
    // edge as the clear survives. Positions with no physical button are
    // forced to 0.
    always_comb begin
        req_up_d  = ((req_up_q  & ~clr_vec) | (rise_up  & ~press_mask)) & 4'b0111;
        req_dn_d  = ((req_dn_q  & ~clr_vec) | (rise_dn  & ~press_mask)) & 4'b1110;
        req_car_d =  (req_car_q & ~clr_vec) | (rise_car & ~press_mask);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            req_up_q  <= 4'd0;
            req_dn_q  <= 4'd0;
            req_car_q <= 4'd0;
        end else begin
            req_up_q  <= req_up_d;
            req_dn_q  <= req_dn_d;
            req_car_q <= req_car_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_up_o     = req_up_q;
    assign req_dn_o     = req_dn_q;
    assign req_car_o    = req_car_q;
    assign floor_o      = floor_q;
    assign at_floor_o   = at_floor;
    assign door_busy_o  = (state_q == S_DWELL) || (state_q == S_CLEAR);
    assign served_o     = (state_q == S_CLEAR);
    assign sensor_err_o = sensor_err_q;
    assign state_o      = state_q;

endmodule
